// File: rtl/inst_axi_pkg.sv
// Shared FSM encoding and AXI protocol constants for the instruction-side SRAM-to-AXI bridge.
package inst_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    WACK = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/inst_axi_bridge.sv
// SRAM-like instruction-cache port to single-beat AXI read bridge, one transaction outstanding.
// Optional sticky read-response error flag enabled by macro INST_BRIDGE_RESP_CHECK_EN.
module inst_axi_bridge
  import inst_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_inst_req,
  input  logic        cache_inst_wr,
  input  logic [1:0]  cache_inst_size,
  input  logic [31:0] cache_inst_addr,
  input  logic [31:0] cache_inst_wdata,
  output logic [31:0] cache_inst_rdata,
  output logic        cache_inst_addr_ok,
  output logic        cache_inst_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_BRIDGE_RESP_CHECK_EN
  ,
  output logic        resp_err
`endif
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        w_latch;
  logic        w_addr_ok;
  logic        w_data_ok;

  // Write data, ID and last are irrelevant with a single outstanding read.
  logic w_unused_ok;
  assign w_unused_ok = ^{cache_inst_wdata, rid, rlast, rresp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= 32'h0;
      r_size  <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr <= cache_inst_addr;
        r_size <= cache_inst_size;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_addr_ok    = 1'b0;
    w_data_ok    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cache_inst_req) begin
          if (cache_inst_wr) begin
            w_addr_ok    = 1'b1;
            w_state_next = WACK;
          end else begin
            w_latch      = 1'b1;
            w_state_next = AR;
          end
        end
      end
      AR: begin
        if (arready) begin
          w_addr_ok    = 1'b1;
          w_state_next = R;
        end
      end
      R: begin
        if (rvalid) begin
          w_data_ok    = 1'b1;
          w_state_next = IDLE;
        end
      end
      WACK: begin
        w_data_ok    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Handshakes are masked while reset is held so a pending write cannot be acknowledged.
  assign cache_inst_addr_ok = w_addr_ok & ~rst;
  assign cache_inst_data_ok = w_data_ok & ~rst;
  assign cache_inst_rdata   = (r_state == WACK) ? 32'h0 : rdata;

  assign arvalid = (r_state == AR);
  assign rready  = (r_state == R);
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arid    = AXI_ID;
  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

`ifdef INST_BRIDGE_RESP_CHECK_EN
  logic r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_err <= 1'b0;
    end else if (rvalid && rready && (rresp != RESP_OKAY)) begin
      r_resp_err <= 1'b1;
    end
  end

  assign resp_err = r_resp_err;
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed scoreboard bench for inst_axi_bridge; resp_err checks compile in with INST_BRIDGE_RESP_CHECK_EN.
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef INST_BRIDGE_RESP_CHECK_EN
  logic        resp_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  inst_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk                (clk),
    .rst                (rst),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (cache_inst_rdata),
    .cache_inst_addr_ok (cache_inst_addr_ok),
    .cache_inst_data_ok (cache_inst_data_ok),
    .arid               (arid),
    .araddr             (araddr),
    .arlen              (arlen),
    .arsize             (arsize),
    .arburst            (arburst),
    .arlock             (arlock),
    .arcache            (arcache),
    .arprot             (arprot),
    .arvalid            (arvalid),
    .arready            (arready),
    .rid                (rid),
    .rdata              (rdata),
    .rresp              (rresp),
    .rlast              (rlast),
    .rvalid             (rvalid),
    .rready             (rready)
`ifdef INST_BRIDGE_RESP_CHECK_EN
    ,
    .resp_err           (resp_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Starts and ends 1 time unit after a rising edge with the bridge in IDLE.
  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input int ar_wait, input int r_wait, input bit chain,
                         input logic [31:0] next_a);
    int addr_ok_cnt;
    int data_ok_cnt;
    addr_ok_cnt = 0;
    data_ok_cnt = 0;
    cache_inst_req  = 1'b1;
    cache_inst_wr   = 1'b0;
    cache_inst_addr = a;
    cache_inst_size = sz;
    arready = 1'b0;
    rvalid  = 1'b0;
    sb.push_back(d);
    smp();
    chk("req_cycle_arvalid", {31'b0, arvalid}, 32'd0);
    chk("req_cycle_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd0);
    step();
    // Disturb the request inputs: the bridge must keep using the latched values.
    cache_inst_req  = 1'b1;
    cache_inst_wr   = 1'b1;
    cache_inst_addr = 32'hFFFF_FFFF;
    cache_inst_size = 2'b11;
    for (int k = 0; k <= ar_wait; k++) begin
      arready = (k == ar_wait);
      smp();
      chk("ar_arvalid", {31'b0, arvalid}, 32'd1);
      chk("ar_araddr", araddr, a);
      chk("ar_arsize", {29'b0, arsize}, {29'b0, 1'b0, sz});
      chk("ar_consts", {9'b0, arid, arlen, arburst, arlock, arcache, arprot},
          {9'b0, 4'd0, 8'd0, 2'b01, 2'b00, 4'b0000, 3'b000});
      chk("ar_rready", {31'b0, rready}, 32'd0);
      chk("ar_addr_ok", {31'b0, cache_inst_addr_ok}, {31'b0, arready});
      if (cache_inst_addr_ok) addr_ok_cnt++;
      step();
    end
    arready = 1'b0;
    for (int k = 0; k <= r_wait; k++) begin
      rvalid = (k == r_wait);
      rdata  = rvalid ? d : (32'h5A5A_0000 + k);
      if (rvalid) begin
        cache_inst_req  = chain;
        cache_inst_wr   = 1'b0;
        cache_inst_addr = chain ? next_a : 32'h0;
        cache_inst_size = sz;
      end
      smp();
      chk("r_arvalid", {31'b0, arvalid}, 32'd0);
      chk("r_rready", {31'b0, rready}, 32'd1);
      chk("r_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd0);
      chk("r_data_ok", {31'b0, cache_inst_data_ok}, {31'b0, rvalid});
      if (cache_inst_data_ok) data_ok_cnt++;
      if (rvalid) chk("r_rdata", cache_inst_rdata, sb.pop_front());
      step();
    end
    rvalid = 1'b0;
    chk("addr_ok_pulses", addr_ok_cnt, 32'd1);
    chk("data_ok_pulses", data_ok_cnt, 32'd1);
    $display("read addr=%h size=%0d data=%h ar_wait=%0d r_wait=%0d chain=%0d",
             a, sz, d, ar_wait, r_wait, chain);
    if (!chain) begin
      smp();
      chk("post_arvalid", {31'b0, arvalid}, 32'd0);
      chk("post_rready", {31'b0, rready}, 32'd0);
      chk("post_data_ok", {31'b0, cache_inst_data_ok}, 32'd0);
      step();
    end
  endtask

  task automatic do_write(input logic [31:0] a);
    rdata = 32'hDEAD_BEEF;
    cache_inst_req  = 1'b1;
    cache_inst_wr   = 1'b1;
    cache_inst_addr = a;
    sb.push_back(32'h0);
    smp();
    chk("wr_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd1);
    chk("wr_data_ok_early", {31'b0, cache_inst_data_ok}, 32'd0);
    chk("wr_arvalid0", {31'b0, arvalid}, 32'd0);
    step();
    cache_inst_addr = a + 32'h4;
    smp();
    chk("wack_data_ok", {31'b0, cache_inst_data_ok}, 32'd1);
    chk("wack_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd0);
    chk("wack_arvalid", {31'b0, arvalid}, 32'd0);
    chk("wack_rdata", cache_inst_rdata, sb.pop_front());
    step();
    cache_inst_req = 1'b0;
    cache_inst_wr  = 1'b0;
    smp();
    chk("wr_post_data_ok", {31'b0, cache_inst_data_ok}, 32'd0);
    chk("wr_post_arvalid", {31'b0, arvalid}, 32'd0);
    step();
    $display("write addr=%h", a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cache_inst_req   = 1'b1;
    cache_inst_wr    = 1'b1;
    cache_inst_size  = 2'b00;
    cache_inst_addr  = 32'h0;
    cache_inst_wdata = 32'h0;
    arready = 1'b0;
    rid     = 4'd0;
    rdata   = 32'h0;
    rresp   = 2'b00;
    rlast   = 1'b1;
    rvalid  = 1'b0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, cache_inst_data_ok}, 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arsize", {29'b0, arsize}, 32'd0);
`ifdef INST_BRIDGE_RESP_CHECK_EN
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
`endif
    step();
    rst = 1'b0;
    cache_inst_req = 1'b0;
    cache_inst_wr  = 1'b0;

    do_read(32'hBFC0_0004, 2'd2, 32'h2408_0001, 0, 0, 1'b0, 32'h0);
    do_read(32'h8000_0100, 2'd1, 32'h1357_9BDF, 3, 4, 1'b0, 32'h0);
    do_write(32'h0000_0010);

    // Abort a read while the bridge waits in R for rvalid.
    cache_inst_req  = 1'b1;
    cache_inst_wr   = 1'b0;
    cache_inst_addr = 32'h1234_5678;
    cache_inst_size = 2'd2;
    step();
    cache_inst_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    step();
    smp();
    chk("midr_rready", {31'b0, rready}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midr_rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("midr_rst_rready", {31'b0, rready}, 32'd0);
    chk("midr_rst_data_ok", {31'b0, cache_inst_data_ok}, 32'd0);
    chk("midr_rst_addr_ok", {31'b0, cache_inst_addr_ok}, 32'd0);
    chk("midr_rst_araddr", araddr, 32'h0);
    $display("reset asserted mid-R");
    step();
    rst = 1'b0;
    do_read(32'h0000_2000, 2'd2, 32'hCAFE_0001, 1, 0, 1'b0, 32'h0);

    do_read(32'hBFC0_0100, 2'd2, 32'h1111_2222, 0, 1, 1'b1, 32'hBFC0_0104);
    do_read(32'hBFC0_0104, 2'd2, 32'h3333_4444, 0, 0, 1'b0, 32'h0);

    rresp = 2'b10;
    do_read(32'h0000_3000, 2'd2, 32'h0BAD_0BAD, 0, 0, 1'b0, 32'h0);
    rresp = 2'b00;
`ifdef INST_BRIDGE_RESP_CHECK_EN
    smp();
    chk("resp_err_set", {31'b0, resp_err}, 32'd1);
    step();
`endif
    do_read(32'h0000_3004, 2'd0, 32'h0000_00AB, 0, 2, 1'b0, 32'h0);
`ifdef INST_BRIDGE_RESP_CHECK_EN
    smp();
    chk("resp_err_sticky", {31'b0, resp_err}, 32'd1);
    rst = 1'b1;
    #1;
    chk("resp_err_clr", {31'b0, resp_err}, 32'd0);
    step();
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
